// File: rtl/spi_flash_reader_if.sv
// Bundle between the serial-flash reader and its environment: pacing tick,
// transfer request/status, byte stream to the frame/audio buffer, and the SPI pins.
interface spi_flash_reader_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 16
);
    logic                  SPI_clk_en;
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [LEN_WIDTH-1:0]  byte_count;
    logic                  busy;
    logic                  done;
    logic [7:0]            data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  spi_sclk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;

    modport master (
        input  SPI_clk_en, start, start_addr, byte_count, data_ready, spi_miso,
        output busy, done, data_out, data_valid, spi_sclk, spi_cs_n, spi_mosi
    );

    modport slave (
        output SPI_clk_en, start, start_addr, byte_count, data_ready, spi_miso,
        input  busy, done, data_out, data_valid, spi_sclk, spi_cs_n, spi_mosi
    );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash reader: READ opcode + 24-bit address, then N bytes streamed
// out on valid/ready; SCLK is paced by SPI_clk_en and stretched on back-pressure.
module spi_flash_reader #(
    parameter logic [7:0] CMD_READ   = 8'h03,
    parameter int         ADDR_WIDTH = 24,
    parameter int         LEN_WIDTH  = 16
) (
    input logic                CLK_40,
    input logic                reset_n,
    spi_flash_reader_if.master bus
);
    localparam int SH_W = 8 + ADDR_WIDTH;
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SHIFT_OUT, SHIFT_IN, STALL, CS_HOLD, FINISH
    } state_t;

    state_t               state, state_d;
    logic                 sclk, sclk_d;
    logic                 cs_n, cs_n_d;
    logic                 mosi, mosi_d;
    logic                 busy, busy_d;
    logic                 done, done_d;
    logic                 valid, valid_d;
    logic [7:0]           dout, dout_d;
    logic [7:0]           sh_in, sh_in_d;
    logic [SH_W-1:0]      sh_out, sh_out_d;
    logic [4:0]           bit_cnt, bit_cnt_d;
    logic [LEN_WIDTH-1:0] remaining, remaining_d;
    logic                 rise, fall, load;

    // SCLK level decides which half of the bit a tick belongs to
    assign rise = bus.SPI_clk_en && !sclk;
    assign fall = bus.SPI_clk_en && sclk;

    always_comb begin
        state_d     = state;
        sclk_d      = sclk;
        cs_n_d      = cs_n;
        mosi_d      = mosi;
        busy_d      = busy;
        done_d      = 1'b0;
        valid_d     = (valid && bus.data_ready) ? 1'b0 : valid;
        dout_d      = dout;
        sh_in_d     = sh_in;
        sh_out_d    = sh_out;
        bit_cnt_d   = bit_cnt;
        remaining_d = remaining;
        load        = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    sh_out_d    = {CMD_READ, bus.start_addr};
                    remaining_d = bus.byte_count;
                    if (bus.byte_count == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CS_SETUP;
                        cs_n_d  = 1'b0;
                        busy_d  = 1'b1;
                        mosi_d  = CMD_READ[7];
                    end
                end
            end
            CS_SETUP: begin
                if (bus.SPI_clk_en) begin
                    state_d   = SHIFT_OUT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT_OUT: begin
                if (rise) begin
                    sclk_d = 1'b1;
                end else if (fall) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        mosi_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = SHIFT_IN;
                    end else begin
                        mosi_d   = sh_out[SH_W-2];
                        sh_out_d = sh_out << 1;
                    end
                end
            end
            SHIFT_IN: begin
                if (rise) begin
                    sclk_d  = 1'b1;
                    sh_in_d = {sh_in[6:0], bus.spi_miso};
                end else if (fall) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        bit_cnt_d = '0;
                        if (!valid || bus.data_ready) load = 1'b1;
                        else                          state_d = STALL;
                    end
                end
            end
            // valid only drops after a consume, so this loads the cycle after it
            STALL: begin
                if (!valid) load = 1'b1;
            end
            CS_HOLD: begin
                if (bus.SPI_clk_en) begin
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            dout_d      = sh_in;
            valid_d     = 1'b1;
            remaining_d = remaining - ONE;
            state_d     = (remaining == ONE) ? CS_HOLD : SHIFT_IN;
        end
    end

    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            dout      <= '0;
            sh_in     <= '0;
            sh_out    <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
        end else begin
            state     <= state_d;
            sclk      <= sclk_d;
            cs_n      <= cs_n_d;
            mosi      <= mosi_d;
            busy      <= busy_d;
            done      <= done_d;
            valid     <= valid_d;
            dout      <= dout_d;
            sh_in     <= sh_in_d;
            sh_out    <= sh_out_d;
            bit_cnt   <= bit_cnt_d;
            remaining <= remaining_d;
        end
    end

    assign bus.spi_sclk   = sclk;
    assign bus.spi_cs_n   = cs_n;
    assign bus.spi_mosi   = mosi;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.data_out   = dout;
    assign bus.data_valid = valid;
endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural flash model on the SPI pins.
module tb_spi_flash_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_flash_reader_if bus ();

    spi_flash_reader dut (
        .CLK_40 (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    // one SPI tick every fourth system clock
    logic [1:0] div = 2'd0;
    always @(posedge clk) div <= div + 2'd1;
    assign bus.SPI_clk_en = (div == 2'd3);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // flash model and pin monitor, sampled on the falling system edge
    logic [7:0]  flash_data [0:7];
    logic [7:0]  rx_q [$];
    int          beat_cyc [$];
    int          cyc = 0, rise_cnt = 0, rises = 0, cs_ticks = 0, cs_falls = 0;
    int          done_cnt = 0, valid_cycles = 0, mosi_nz = 0, sclk_bad = 0;
    logic [31:0] mosi_word = '0;
    logic        busy_at_done = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_en = 1'b0;

    initial bus.spi_miso = 1'b0;

    always @(negedge clk) begin
        int   k;
        logic [7:0] b;
        cyc++;
        if (!bus.spi_cs_n && prev_cs) begin
            cs_falls++;
            rise_cnt  = 0;
            mosi_word = '0;
            cs_ticks  = 0;
            bus.spi_miso = 1'b0;
        end
        if (!bus.spi_cs_n && bus.SPI_clk_en) cs_ticks++;
        if (rst_n && (bus.spi_sclk != prev_sclk) && !prev_en) sclk_bad++;
        if (bus.spi_sclk && !prev_sclk) begin
            rises++;
            if (rise_cnt < 32) mosi_word = {mosi_word[30:0], bus.spi_mosi};
            else if (bus.spi_mosi) mosi_nz++;
            rise_cnt++;
        end
        if (!bus.spi_sclk && prev_sclk) begin
            if (rise_cnt < 32) bus.spi_miso = 1'b0;
            else begin
                k = rise_cnt - 32;
                b = flash_data[(k / 8) % 8];
                bus.spi_miso = b[7 - (k % 8)];
            end
        end
        if (bus.data_valid) valid_cycles++;
        if (bus.data_valid && bus.data_ready) begin
            rx_q.push_back(bus.data_out);
            beat_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt++;
            busy_at_done = bus.busy;
        end
        prev_cs   = bus.spi_cs_n;
        prev_sclk = bus.spi_sclk;
        prev_en   = bus.SPI_clk_en;
    end

    task automatic xfer(input logic [23:0] addr, input logic [15:0] cnt);
        @(posedge clk); #1;
        bus.start_addr = addr;
        bus.byte_count = cnt;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 5000), 32'd1);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int d0, r0, v0, b0, f0, s0, n;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.byte_count = '0;
        bus.data_ready = 1'b0;
        for (int i = 0; i < 8; i++) flash_data[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", bus.spi_cs_n, 1);
        chk("rst_sclk", bus.spi_sclk, 0);
        chk("rst_mosi", bus.spi_mosi, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_valid", bus.data_valid, 0);
        chk("rst_dout", bus.data_out, 0);
        rst_n = 1'b1;

        // single byte
        flash_data[0] = 8'hA5;
        bus.data_ready = 1'b1;
        d0 = done_cnt; r0 = rx_q.size(); v0 = valid_cycles;
        xfer(24'h012345, 16'd1);
        chk("t1_busy", bus.busy, 1);
        chk("t1_cs_low", bus.spi_cs_n, 0);
        wait_done(d0, "t1");
        chk("t1_mosi", mosi_word, 32'h03012345);
        chk("t1_nbytes", rx_q.size() - r0, 1);
        chk("t1_byte", (rx_q.size() > r0) ? rx_q[r0] : 8'hxx, 8'hA5);
        chk("t1_valid_cyc", valid_cycles - v0, 1);
        chk("t1_cs_ticks", cs_ticks, 82);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_busy_at_done", busy_at_done, 0);
        chk("t1_cs_high", bus.spi_cs_n, 1);

        // four back-to-back bytes
        flash_data[0] = 8'h11; flash_data[1] = 8'h22; flash_data[2] = 8'h33; flash_data[3] = 8'h44;
        d0 = done_cnt; r0 = rx_q.size(); b0 = beat_cyc.size();
        xfer(24'hABCDEF, 16'd4);
        wait_done(d0, "t2");
        chk("t2_mosi", mosi_word, 32'h03ABCDEF);
        chk("t2_nbytes", rx_q.size() - r0, 4);
        if (rx_q.size() - r0 == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("t2_byte%0d", i), rx_q[r0 + i], flash_data[i]);
            for (int i = 1; i < 4; i++)
                chk($sformatf("t2_gap%0d", i), beat_cyc[b0 + i] - beat_cyc[b0 + i - 1], 64);
        end
        chk("t2_cs_ticks", cs_ticks, 130);
        chk("t2_done_cnt", done_cnt - d0, 1);

        // back-pressure: ready held low until 100 cycles after the first byte
        flash_data[0] = 8'h5A; flash_data[1] = 8'hC3; flash_data[2] = 8'h7E;
        bus.data_ready = 1'b0;
        d0 = done_cnt; r0 = rx_q.size();
        xfer(24'h000100, 16'd3);
        n = 0;
        while (!bus.data_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t3_valid_timeout", 32'(n < 3000), 1);
        repeat (99) @(negedge clk);
        chk("t3_stall_rises", rise_cnt, 48);
        chk("t3_stall_sclk", bus.spi_sclk, 0);
        chk("t3_stall_dout", bus.data_out, 8'h5A);
        @(posedge clk); #1;
        bus.data_ready = 1'b1;
        wait_done(d0, "t3");
        chk("t3_nbytes", rx_q.size() - r0, 3);
        if (rx_q.size() - r0 == 3)
            for (int i = 0; i < 3; i++) chk($sformatf("t3_byte%0d", i), rx_q[r0 + i], flash_data[i]);
        chk("t3_rises", rise_cnt, 56);
        chk("t3_done_cnt", done_cnt - d0, 1);

        // zero-length request
        d0 = done_cnt; f0 = cs_falls; s0 = rises;
        xfer(24'h123456, 16'd0);
        chk("t4_done", bus.done, 1);
        chk("t4_busy", bus.busy, 0);
        repeat (6) @(posedge clk);
        chk("t4_done_cnt", done_cnt - d0, 1);
        chk("t4_cs_falls", cs_falls - f0, 0);
        chk("t4_rises", rises - s0, 0);

        // reset mid-address, then a clean transfer
        xfer(24'h00FF00, 16'd2);
        n = 0;
        while (!(rise_cnt >= 10 && bus.spi_sclk) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_wait_timeout", 32'(n < 3000), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_cs_n", bus.spi_cs_n, 1);
        chk("t5_sclk", bus.spi_sclk, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_valid", bus.data_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        flash_data[0] = 8'h96; flash_data[1] = 8'h69;
        d0 = done_cnt; r0 = rx_q.size();
        xfer(24'h102030, 16'd2);
        wait_done(d0, "t5");
        chk("t5_mosi", mosi_word, 32'h03102030);
        chk("t5_nbytes", rx_q.size() - r0, 2);
        if (rx_q.size() - r0 == 2) begin
            chk("t5_byte0", rx_q[r0], 8'h96);
            chk("t5_byte1", rx_q[r0 + 1], 8'h69);
        end
        chk("t5_cs_ticks", cs_ticks, 98);

        // second start while busy must be ignored
        flash_data[0] = 8'hDE; flash_data[1] = 8'hAD;
        d0 = done_cnt; r0 = rx_q.size(); f0 = cs_falls;
        xfer(24'h00BEEF, 16'd2);
        repeat (20) @(posedge clk);
        #1;
        bus.start_addr = 24'h777777;
        bus.byte_count = 16'd5;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        wait_done(d0, "t6");
        repeat (20) @(posedge clk);
        chk("t6_mosi", mosi_word, 32'h0300BEEF);
        chk("t6_nbytes", rx_q.size() - r0, 2);
        if (rx_q.size() - r0 == 2) begin
            chk("t6_byte0", rx_q[r0], 8'hDE);
            chk("t6_byte1", rx_q[r0 + 1], 8'hAD);
        end
        chk("t6_cs_ticks", cs_ticks, 98);
        chk("t6_done_cnt", done_cnt - d0, 1);
        chk("t6_cs_falls", cs_falls - f0, 1);

        chk("mosi_zero_in_data", mosi_nz, 0);
        chk("sclk_only_on_tick", sclk_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- SPI mode-0 master that streams video/audio data out of the external serial flash.
- Paced by SPI_clk_en from the clock-enable generator; one SCLK edge per enable tick.
- Issues a READ command and a 24-bit address, then clocks in byte_count bytes.
- Delivers each byte on a valid/ready interface to the downstream frame/audio buffer, stretching SCLK when that buffer back-pressures.

Parameters:
- CMD_READ, 8'h03, flash read opcode, shifted out MSB first.
- ADDR_WIDTH, 24, width of the flash address.
- LEN_WIDTH, 16, width of the byte-count field.

Ports:
- CLK_40  input  1  system clock, 40 MHz.
- reset_n  input  1  reset, asynchronous, active-low.
- SPI_clk_en  input  1  single-cycle tick; all SPI pin activity advances only on ticks.
- start  input  1  request a transfer; sampled only in IDLE.
- start_addr  input  ADDR_WIDTH  flash start address, latched on an accepted start.
- byte_count  input  LEN_WIDTH  number of bytes to read, latched on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at the end of a transfer.
- data_out  output  8  received byte.
- data_valid  output  1  data_out holds an unconsumed byte.
- data_ready  input  1  consumer accepts the byte when data_valid && data_ready.
- spi_sclk  output  1  SPI clock; idles low.
- spi_cs_n  output  1  chip select, active-low.
- spi_mosi  output  1  master-out serial data.
- spi_miso  input  1  master-in serial data.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0.
  - busy=0, done=0, data_valid=0, data_out=0.
  - State returns to IDLE.
- States: IDLE, CS_SETUP, SHIFT_OUT, SHIFT_IN, STALL, CS_HOLD, FINISH.
- IDLE:
  - On start=1, latch start_addr and byte_count.
  - If byte_count==0: go to FINISH; spi_cs_n stays high.
  - Otherwise, on the next cycle: spi_cs_n=0, busy=1, spi_mosi=CMD_READ[7]; go to CS_SETUP.
  - start while busy is ignored.
- CS_SETUP: wait for one tick with SCLK low (CS setup time), then go to SHIFT_OUT.
- Bit timing, two ticks per bit:
  - Rising tick: spi_sclk<=1 and spi_miso is sampled into the shift register.
  - Falling tick: spi_sclk<=0 and spi_mosi is updated to the next bit.
- SHIFT_OUT:
  - Shifts 32 bits, MSB first: {CMD_READ, start_addr}.
  - On the falling tick of bit 31, spi_mosi<=0 and the state goes to SHIFT_IN.
  - spi_mosi stays 0 for the rest of the transfer.
- SHIFT_IN:
  - 8 bits per byte, MSB first.
  - On the falling tick after the 8th rising sample, the byte is complete.
  - If data_valid==0, or data_valid && data_ready in that same cycle: data_out<=byte, data_valid<=1, remaining count decrements.
  - Otherwise go to STALL with SCLK held low.
- STALL:
  - Wait for the output register to become free (data_valid && data_ready).
  - The cycle after, load the pending byte, set data_valid, and decrement the count.
  - Resume on the next tick.
  - No SCLK edge is produced while stalled.
- data_valid clears on any cycle with data_ready=1 and no new load in that cycle.
- After the last byte is loaded, go to CS_HOLD: one tick with SCLK low, then spi_cs_n<=1 and go to FINISH.
- FINISH:
  - done=1 for exactly one cycle; busy<=0 in the same cycle; return to IDLE.
  - data_valid may still be high during done (the last byte is not yet consumed).
  - A new start is accepted in IDLE even if data_valid=1. A fresh byte cannot overwrite it: it takes the STALL path.
- Counting:
  - Remaining count is LEN_WIDTH bits and is checked for ==1 before decrementing, so there is no wrap.
  - The address is not incremented internally; the flash auto-increments.
- Unstalled duration is (1 + 64 + 16*N + 1) ticks from CS low to CS high.
- Ticks arriving in IDLE/FINISH are ignored.
- spi_sclk never changes except on a tick cycle.

Test Plan:
- Start addr=24'h012345, count=1, miso byte 8'hA5, data_ready=1 → on MOSI: 0x03,0x01,0x23,0x45 MSB first, sampled on SCLK rising edges. data_out=8'hA5 with a one-cycle data_valid. CS low for exactly 82 ticks; done pulses once; busy falls with done.
- count=4, bytes 11,22,33,44, data_ready=1 → four valid beats in order, 16 ticks apart. No SCLK gaps; 130 ticks of CS low.
- count=3, data_ready=0 until 100 cycles after the 1st byte → SCLK held low after byte 2 completes. No SCLK edges during the stall. Bytes delivered in order after ready rises; no byte lost or duplicated.
- count=0 → done pulses one cycle later; spi_cs_n never goes low; no SCLK edges.
- reset_n dropped mid-address phase → same cycle spi_cs_n=1, spi_sclk=0, busy=0, data_valid=0. A subsequent start runs a full, correct transfer.
- start pulsed again while busy, with different addr → ignored; original transfer completes unchanged; exactly one done pulse.
